hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline controller for the 5-stage RISC-V core; sequences the execute stage's operand forwarding, load-use stalls, taken-branch flushes and multi-cycle execute operations (mul/div unit handshake).
- Tracks the execute-stage source registers internally.
- Drives stall/bubble/flush controls to fetch, decode→execute and execute→memory pipeline registers.
- Drives forwarding selects to the execute-stage bus_a/bus_b muxes.

Parameters:
REG_COUNT, 32, number of architectural registers
REG_BITS, $clog2(REG_COUNT), register index width
CNT_WIDTH, 32, stall performance counter width
MC_TIMEOUT, 64, max cycles waiting for mc_done before error

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
dec_rs1, dec_rs2  in  REG_BITS  decode-stage source indices
dec_rs1_used, dec_rs2_used  in  1  decode instruction reads rs1/rs2
dec_rd  in  REG_BITS  decode-stage destination
dec_mem_read  in  1  decode instruction is a load
dec_mc  in  1  decode instruction is multi-cycle
mem_rd  in  REG_BITS  exc_mem_reg destination
mem_write_en  in  1  exc_mem_reg write enable
wb_rd  in  REG_BITS  mem_wb destination
wb_write_en  in  1  mem_wb write enable
branch_taken  in  1  execute resolves taken branch/jump
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
fwd_a_sel, fwd_b_sel  out  2  0=register file, 1=exc_mem ALU result, 2=writeback data
stall_fetch  out  1  hold PC
stall_decode  out  1  hold fetch→decode register
bubble_execute  out  1  load NOP into dec_exc_reg
flush_decode  out  1  load NOP into fetch→decode register
hold_execute  out  1  hold dec_exc_reg; load NOP into exc_mem_reg
mc_start  out  1  start pulse to multi-cycle unit
mc_error  out  1  sticky timeout flag
stall_count  out  CNT_WIDTH  saturating count of stalled cycles

Behaviour:
- Internal exe-stage copy: exe_rs1/exe_rs2/used bits, exe_rd, exe_mem_read, exe_mc.
  - rstn=0 or bubble_execute → all cleared.
  - Else stall_decode=0 → capture dec_*.
  - Else hold.
- Forwarding (combinational from the exe copy), per operand:
  - sel=1 if used && rs!=0 && mem_write_en && mem_rd==rs.
  - Else sel=2 if used && rs!=0 && wb_write_en && wb_rd==rs.
  - Else 0. Mem stage wins over wb. x0 is never forwarded.
- FSM states RUN, MC_WAIT.
- RUN:
  - Taken branch (priority 1): branch_taken → flush_decode=1, bubble_execute=1, no stall. A load-use hit in the same cycle is ignored.
  - Multi-cycle start (priority 2): exe_mc && !branch_taken → mc_start=1 for exactly this cycle; next state MC_WAIT; timer=0.
  - Load-use (priority 3): exe_mem_read && exe_rd!=0 && matches a used dec_rs → stall_fetch=stall_decode=bubble_execute=1 for one cycle.
- MC_WAIT:
  - Asserts stall_fetch, stall_decode and hold_execute every cycle; bubble_execute=0; mc_start=0.
  - mc_done → RUN next cycle, outputs released in that same RUN cycle, exe_mc cleared on that edge.
  - Timer reaches MC_TIMEOUT-1 without mc_done → mc_error=1 (sticky until reset) → RUN.
- Stall counting: stall_count +1 on every cycle with stall_fetch=1; saturates at all-ones, never wraps.
- Reset: all outputs 0, state RUN, timer 0, mc_error 0, stall_count 0. Reset mid-MC_WAIT aborts to RUN with no mc_start replay.
- mc_done while in RUN is ignored.
- Latency: all control outputs are combinational from current state and inputs (same cycle); state and the exe copy update on the clk edge.

Decomposition:
- Package hazard_pkg holds:
  - state enum {RUN, MC_WAIT};
  - FWD_RF=0, FWD_MEM=1, FWD_WB=2 constants;
  - fwd_sel_t typedef.
- One sub-module fwd_unit: the combinational per-operand forwarding compare, instantiated twice.

Test Plan:
- exe uses x5,x6; mem_rd=5 mem_write_en=1; wb_rd=6 wb_write_en=1 → fwd_a_sel=1, fwd_b_sel=2; then mem_rd=wb_rd=5 → fwd_a_sel=1 (mem priority); rs=0 with mem_rd=0 → sel 0.
- Load x7 in exe, dec_rs2=7 used → one cycle of stall_fetch/stall_decode/bubble_execute, stall_count=1, then exe copy cleared and decode advances.
- Load-use and branch_taken in same cycle → flush_decode=1, bubble_execute=1, stall_fetch=0, stall_count unchanged.
- exe_mc=1 → mc_start pulse one cycle, 5 cycles MC_WAIT with hold_execute=1, mc_done → release next cycle; stall_count=6.
- exe_mc, no mc_done for MC_TIMEOUT=64 cycles → mc_error=1, return to RUN, mc_error held until rstn=0.
- rstn=0 during MC_WAIT → next cycle all outputs 0, state RUN; stall_count preset near max then 3 stalls → stays at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// FSM state encoding and forwarding-select codes.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_MEM = 2'd1;
    localparam fwd_sel_t FWD_WB  = 2'd2;

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// Per-operand forwarding compare for the execute stage.
// The younger mem-stage result beats writeback; x0 never forwards.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_BITS = 5
) (
    input  logic [REG_BITS-1:0] rs_i,
    input  logic                used_i,
    input  logic [REG_BITS-1:0] mem_rd_i,
    input  logic                mem_we_i,
    input  logic [REG_BITS-1:0] wb_rd_i,
    input  logic                wb_we_i,
    output fwd_sel_t            sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (used_i && rs_i != '0) begin
            if (mem_we_i && mem_rd_i == rs_i) begin
                sel_o = FWD_MEM;
            end else if (wb_we_i && wb_rd_i == rs_i) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stalls,
// branch flushes and the multi-cycle execute handshake.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_COUNT  = 32,
    parameter int REG_BITS   = $clog2(REG_COUNT),
    parameter int CNT_WIDTH  = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [REG_BITS-1:0]  dec_rs1,
    input  logic [REG_BITS-1:0]  dec_rs2,
    input  logic                 dec_rs1_used,
    input  logic                 dec_rs2_used,
    input  logic [REG_BITS-1:0]  dec_rd,
    input  logic                 dec_mem_read,
    input  logic                 dec_mc,
    input  logic [REG_BITS-1:0]  mem_rd,
    input  logic                 mem_write_en,
    input  logic [REG_BITS-1:0]  wb_rd,
    input  logic                 wb_write_en,
    input  logic                 branch_taken,
    input  logic                 mc_done,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic                 stall_fetch,
    output logic                 stall_decode,
    output logic                 bubble_execute,
    output logic                 flush_decode,
    output logic                 hold_execute,
    output logic                 mc_start,
    output logic                 mc_error,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(MC_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [REG_BITS-1:0]    exe_rs1_q, exe_rs2_q, exe_rd_q;
    logic                   exe_rs1_used_q, exe_rs2_used_q;
    logic                   exe_ld_q, exe_mc_q;
    logic                   mc_clr;
    logic                   load_use;

    fwd_unit #(.REG_BITS(REG_BITS)) u_fwd_a (
        .rs_i     (exe_rs1_q),
        .used_i   (exe_rs1_used_q),
        .mem_rd_i (mem_rd),
        .mem_we_i (mem_write_en),
        .wb_rd_i  (wb_rd),
        .wb_we_i  (wb_write_en),
        .sel_o    (fwd_a_sel)
    );

    fwd_unit #(.REG_BITS(REG_BITS)) u_fwd_b (
        .rs_i     (exe_rs2_q),
        .used_i   (exe_rs2_used_q),
        .mem_rd_i (mem_rd),
        .mem_we_i (mem_write_en),
        .wb_rd_i  (wb_rd),
        .wb_we_i  (wb_write_en),
        .sel_o    (fwd_b_sel)
    );

    assign load_use = exe_ld_q && exe_rd_q != '0 &&
                      ((dec_rs1_used && dec_rs1 == exe_rd_q) ||
                       (dec_rs2_used && dec_rs2 == exe_rd_q));

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        err_d          = err_q;
        mc_clr         = 1'b0;
        stall_fetch    = 1'b0;
        stall_decode   = 1'b0;
        bubble_execute = 1'b0;
        flush_decode   = 1'b0;
        hold_execute   = 1'b0;
        mc_start       = 1'b0;
        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    flush_decode   = 1'b1;
                    bubble_execute = 1'b1;
                end else if (exe_mc_q) begin
                    mc_start = 1'b1;
                    state_d  = MC_WAIT;
                    timer_d  = '0;
                end else if (load_use) begin
                    stall_fetch    = 1'b1;
                    stall_decode   = 1'b1;
                    bubble_execute = 1'b1;
                end
            end
            MC_WAIT: begin
                stall_fetch  = 1'b1;
                stall_decode = 1'b1;
                hold_execute = 1'b1;
                // Leaving on timeout also retires the op so RUN won't restart it
                if (mc_done) begin
                    state_d = RUN;
                    mc_clr  = 1'b1;
                end else if (timer_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = RUN;
                    mc_clr  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= RUN;
            timer_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            if (stall_fetch && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || bubble_execute) begin
            exe_rs1_q      <= '0;
            exe_rs2_q      <= '0;
            exe_rs1_used_q <= 1'b0;
            exe_rs2_used_q <= 1'b0;
            exe_rd_q       <= '0;
            exe_ld_q       <= 1'b0;
            exe_mc_q       <= 1'b0;
        end else if (!stall_decode) begin
            exe_rs1_q      <= dec_rs1;
            exe_rs2_q      <= dec_rs2;
            exe_rs1_used_q <= dec_rs1_used;
            exe_rs2_used_q <= dec_rs2_used;
            exe_rd_q       <= dec_rd;
            exe_ld_q       <= dec_mem_read;
            exe_mc_q       <= dec_mc;
        end else if (mc_clr) begin
            exe_mc_q <= 1'b0;
        end
    end

    assign mc_error    = err_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_rs1_used, dec_rs2_used, dec_mem_read, dec_mc;
    logic [4:0] mem_rd, wb_rd;
    logic       mem_write_en, wb_write_en, branch_taken, mc_done;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall_fetch, stall_decode, bubble_execute;
    logic       flush_decode, hold_execute, mc_start, mc_error;
    logic [6:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    hazard_ctrl #(.CNT_WIDTH(7)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_rs1_used   (dec_rs1_used),
        .dec_rs2_used   (dec_rs2_used),
        .dec_rd         (dec_rd),
        .dec_mem_read   (dec_mem_read),
        .dec_mc         (dec_mc),
        .mem_rd         (mem_rd),
        .mem_write_en   (mem_write_en),
        .wb_rd          (wb_rd),
        .wb_write_en    (wb_write_en),
        .branch_taken   (branch_taken),
        .mc_done        (mc_done),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .stall_fetch    (stall_fetch),
        .stall_decode   (stall_decode),
        .bubble_execute (bubble_execute),
        .flush_decode   (flush_decode),
        .hold_execute   (hold_execute),
        .mc_start       (mc_start),
        .mc_error       (mc_error),
        .stall_count    (stall_count)
    );

    typedef struct {
        int rs1; int u1; int rs2; int u2; int rd; int ld; int mc;
        int mrd; int mwe; int wrd; int wwe; int br; int dn;
        int fa; int fb; int ctl; int cnt;
    } vec_t;

    vec_t tbl[10];

    // {stall_fetch, stall_decode, bubble, flush, hold, mc_start}
    function automatic logic [31:0] ctl();
        return {26'd0, stall_fetch, stall_decode, bubble_execute,
                flush_decode, hold_execute, mc_start};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop_in();
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_rs1_used = 0; dec_rs2_used = 0;
        dec_mem_read = 0; dec_mc = 0;
        mem_rd = 0; wb_rd = 0; mem_write_en = 0; wb_write_en = 0;
        branch_taken = 0; mc_done = 0;
    endtask

    task automatic apply(input vec_t v);
        dec_rs1 = 5'(v.rs1); dec_rs1_used = v.u1[0];
        dec_rs2 = 5'(v.rs2); dec_rs2_used = v.u2[0];
        dec_rd = 5'(v.rd); dec_mem_read = v.ld[0]; dec_mc = v.mc[0];
        mem_rd = 5'(v.mrd); mem_write_en = v.mwe[0];
        wb_rd = 5'(v.wrd); wb_write_en = v.wwe[0];
        branch_taken = v.br[0]; mc_done = v.dn[0];
    endtask

    task automatic load_use_stall();
        nop_in(); dec_rd = 7; dec_mem_read = 1;
        step();
        nop_in(); dec_rs1 = 7; dec_rs1_used = 1;
        #1 chk("lu_ctl", ctl(), 32'b111000);
        step();
        nop_in();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //          rs1 u1 rs2 u2 rd ld mc mrd mwe wrd wwe br dn fa fb ctl cnt
        tbl[0] = '{5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{5, 1, 6, 1, 0, 0, 0, 5, 1, 6, 1, 0, 0, 1, 2, 0, 0};
        tbl[2] = '{0, 1, 0, 1, 0, 0, 0, 5, 1, 5, 1, 0, 0, 1, 0, 0, 0};
        tbl[3] = '{5, 0, 6, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 1, 0, 0, 7, 1, 0, 5, 1, 6, 1, 0, 0, 0, 2, 0, 0};
        tbl[5] = '{3, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b111000, 0};
        tbl[6] = '{2, 1, 0, 0, 8, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[7] = '{8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'b001100, 1};
        tbl[8] = '{0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[9] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        rstn = 0;
        nop_in();
        step();
        step();
        chk("rst_ctl", ctl(), 0);
        chk("rst_fwd", {fwd_a_sel, fwd_b_sel}, 0);
        chk("rst_cnt", stall_count, 0);
        chk("rst_err", mc_error, 0);
        rstn = 1;

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i]);
            #1;
            chk($sformatf("v%0d_fa", i), fwd_a_sel, tbl[i].fa);
            chk($sformatf("v%0d_fb", i), fwd_b_sel, tbl[i].fb);
            chk($sformatf("v%0d_ctl", i), ctl(), tbl[i].ctl);
            chk($sformatf("v%0d_cnt", i), stall_count, tbl[i].cnt);
            step();
        end

        // multi-cycle op completing after 5 wait cycles
        nop_in(); dec_mc = 1; dec_rd = 9;
        #1 chk("mc_pre", ctl(), 0);
        step();
        nop_in();
        #1 chk("mc_start", ctl(), 32'b000001);
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("mc_wait%0d", k), ctl(), 32'b110010);
            step();
        end
        mc_done = 1;
        #1 chk("mc_done_cyc", ctl(), 32'b110010);
        step();
        mc_done = 0;
        #1 chk("mc_release", ctl(), 0);
        chk("mc_cnt", stall_count, 7);
        step();

        // stray mc_done in RUN
        mc_done = 1;
        #1 chk("run_done", ctl(), 0);
        step();
        mc_done = 0;
        #1 chk("run_done_after", ctl(), 0);
        chk("run_done_cnt", stall_count, 7);
        step();

        // reset in the middle of MC_WAIT
        dec_mc = 1;
        step();
        nop_in();
        #1 chk("rmc_start", ctl(), 32'b000001);
        step();
        step();
        step();
        chk("rmc_wait", ctl(), 32'b110010);
        rstn = 0;
        step();
        rstn = 1;
        #1 chk("rmc_ctl", ctl(), 0);
        chk("rmc_cnt", stall_count, 0);
        chk("rmc_err", mc_error, 0);
        step();
        chk("rmc_noreplay", ctl(), 0);
        step();

        // timeout: 64 wait cycles then sticky error
        dec_mc = 1;
        step();
        nop_in();
        #1 chk("to_start", ctl(), 32'b000001);
        step();
        n = 0;
        while (stall_fetch && n < 200) begin
            n++;
            step();
        end
        chk("to_cycles", n, 64);
        chk("to_err", mc_error, 1);
        chk("to_ctl", ctl(), 0);
        chk("to_cnt", stall_count, 64);
        step();
        step();
        chk("to_err_sticky", mc_error, 1);
        chk("to_no_restart", ctl(), 0);

        // bring count to 126, then saturate
        dec_mc = 1;
        step();
        nop_in();
        step();
        for (int k = 0; k < 61; k++) step();
        mc_done = 1;
        step();
        mc_done = 0;
        #1 chk("sat_pre_cnt", stall_count, 126);
        chk("sat_err_held", mc_error, 1);
        for (int k = 0; k < 3; k++) load_use_stall();
        chk("sat_cnt", stall_count, 127);

        rstn = 0;
        step();
        rstn = 1;
        #1 chk("final_err", mc_error, 0);
        chk("final_cnt", stall_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
